// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: operand buffer, skew feeder and result capture for systolic_array_8x8
// Ports: clk/rst (sync, active-high); ld_valid/ld_ready/ld_data load port (16 row beats, A rows then B rows);
// busy; arr_rst/arr_en/arr_locked array control; a_in_flat/b_in_flat skew vectors; c_out_flat array result;
// res_valid/res_ready/c_res_flat captured result port.
// Macro SYSTOLIC_GAP_EN: each feed step is a data cycle followed by an all-zero bubble cycle.
module systolic_seq_ctrl #(
  parameter int data_width = 8,
  parameter int acc_width = 32,
  parameter int drain_cycles = 19
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [8*data_width-1:0]   ld_data,
  output logic                      busy,
  output logic                      arr_rst,
  output logic                      arr_en,
  input  logic                      arr_locked,
  output logic [8*data_width-1:0]   a_in_flat,
  output logic [8*data_width-1:0]   b_in_flat,
  input  logic [64*acc_width-1:0]   c_out_flat,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [64*acc_width-1:0]   c_res_flat
);
  localparam logic [2:0] idle = 3'd0, clr = 3'd1, lock = 3'd2, feed = 3'd3, drain = 3'd4, done = 3'd5;
  localparam logic [7:0] drain_last = 8'(drain_cycles - 1);
  logic [2:0] state, nxt_state;
  logic [3:0] beat, step, nxt_step, d;
  logic ph, nxt_ph, clr_n, ld_fire, step_end;
  logic [7:0] dcnt;
  logic [8*data_width-1:0] a_row [8];
  logic [8*data_width-1:0] b_row [8];
  logic [8*data_width-1:0] a_sk, b_sk;
`ifdef SYSTOLIC_GAP_EN
  assign step_end = ph;
`else
  assign step_end = 1'b1;
`endif
  assign ld_ready = state == idle && !rst;
  assign ld_fire = ld_valid && ld_ready;
  assign busy = state != idle;
  assign arr_rst = rst || state == clr;
  always_comb begin
    nxt_state = state;
    nxt_step = step;
    nxt_ph = ph;
    case (state)
      idle: nxt_state = ld_fire && beat == 4'd15 ? clr : idle;
      clr: nxt_state = clr_n ? lock : clr;
      lock: if (arr_locked) begin
        nxt_state = feed;
        nxt_step = 4'd0;
        nxt_ph = 1'b0;
      end
      feed: begin
        nxt_ph = ~step_end;
        if (step_end) begin
          nxt_state = step == 4'd14 ? drain : feed;
          nxt_step = step == 4'd14 ? step : step + 4'd1;
        end
      end
      drain: nxt_state = dcnt == drain_last ? done : drain;
      done: nxt_state = res_valid && res_ready ? idle : done;
      default: nxt_state = idle;
    endcase
    // skew vectors are registered, so they are built for the step about to start
    a_sk = '0;
    b_sk = '0;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      d = nxt_step - 4'(i);
      if (nxt_state == feed && !nxt_ph && nxt_step >= 4'(i) && d < 4'd8) begin
        a_sk[i*data_width +: data_width] = a_row[i][d[2:0]*data_width +: data_width];
        b_sk[i*data_width +: data_width] = b_row[d[2:0]][i*data_width +: data_width];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= idle;
      beat <= '0;
      step <= '0;
      ph <= 1'b0;
      clr_n <= 1'b0;
      dcnt <= '0;
      a_in_flat <= '0;
      b_in_flat <= '0;
      arr_en <= 1'b0;
      res_valid <= 1'b0;
      c_res_flat <= '0;
    end else begin
      state <= nxt_state;
      step <= nxt_step;
      ph <= nxt_ph;
      beat <= ld_fire ? beat + 4'd1 : beat;
      clr_n <= state == clr && !clr_n;
      dcnt <= state == drain ? dcnt + 8'd1 : 8'd0;
      a_in_flat <= a_sk;
      b_in_flat <= b_sk;
      arr_en <= nxt_state inside {lock, feed, drain};
      res_valid <= nxt_state == done;
      if (state == drain && dcnt == drain_last) c_res_flat <= c_out_flat;
    end
  end
  always_ff @(posedge clk) begin
    if (ld_fire && beat[3]) b_row[beat[2:0]] <= ld_data;
    if (ld_fire && !beat[3]) a_row[beat[2:0]] <= ld_data;
  end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: randomized directed bench for systolic_seq_ctrl against a timeline model
module tb_systolic_seq_ctrl;
  localparam int aw = 32;
  localparam int D = 19;
`ifdef SYSTOLIC_GAP_EN
  localparam int G = 2;
`else
  localparam int G = 1;
`endif
  localparam int F = 15 * G;
  logic clk = 1'b0, rst = 1'b1, ld_valid = 1'b0, arr_locked = 1'b0, res_ready = 1'b0;
  logic [63:0] ld_data = '0;
  logic ld_ready, busy, arr_rst, arr_en, res_valid;
  logic [63:0] a_in_flat, b_in_flat;
  logic [64*aw-1:0] c_out_flat = '0;
  logic [64*aw-1:0] c_res_flat, exp_c;
  logic [7:0] A [8][8];
  logic [7:0] B [8][8];
  logic [31:0] seed = 32'h1234_5678;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  systolic_seq_ctrl #(.data_width(8), .acc_width(aw), .drain_cycles(D)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .busy(busy), .arr_rst(arr_rst), .arr_en(arr_en), .arr_locked(arr_locked),
    .a_in_flat(a_in_flat), .b_in_flat(b_in_flat), .c_out_flat(c_out_flat),
    .res_valid(res_valid), .res_ready(res_ready), .c_res_flat(c_res_flat)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_c(input string tag, input logic [64*aw-1:0] exp);
    int e = 0;
    vecs++;
    assert (c_res_flat === exp) else begin
      errs++;
      while (e < 63 && c_res_flat[e*aw +: aw] === exp[e*aw +: aw]) e++;
      $error("FAIL %s elem%0d observed=%h expected=%h", tag, e, c_res_flat[e*aw +: aw], exp[e*aw +: aw]);
    end
  endtask
  function automatic logic [64*aw-1:0] pat(input int k);
    logic [64*aw-1:0] r;
    for (int e = 0; e < 64; e++) r[e*aw +: aw] = seed + 32'(k * 977) + 32'(e * 65537);
    return r;
  endfunction
  function automatic logic [63:0] row(input int n);
    logic [63:0] r;
    for (int c = 0; c < 8; c++) begin
      if (n < 8) r[c*8 +: 8] = A[n][c];
      else r[c*8 +: 8] = B[n-8][c];
    end
    return r;
  endfunction
  function automatic logic [63:0] skew(input bit is_b, input int t);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      if (t - i >= 0 && t - i < 8) r[i*8 +: 8] = is_b ? B[t-i][i] : A[i][t-i];
    end
    return r;
  endfunction
  task automatic fill(input bit plan);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        A[i][j] = plan ? 8'(8*i + j + 1) : 8'($urandom);
        B[i][j] = plan ? 8'(64 - (8*i + j)) : 8'($urandom);
      end
    seed = $urandom;
  endtask
  task automatic load(input int n, input bit gaps);
    for (int b = 0; b < n; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        ld_valid = 1'b0;
        ld_data = {$urandom, $urandom};
        chk("idle_busy", busy, 0);
        tick;
      end
      ld_valid = 1'b1;
      ld_data = row(b);
      chk("ld_ready", ld_ready, 1);
      tick;
    end
    ld_valid = 1'b0;
  endtask
  // k counts cycles after the 16th beat edge; lk = cycles arr_locked is held low in LOCK
  task automatic run_op(input int lk, input int rd, input int abort);
    int fs, lat, s;
    bit dat;
    fs = 3 + lk;
    lat = fs + F + D;
    for (int k = 0; k < lat; k++) begin
      s = k - fs;
      dat = k >= fs && k < fs + F && s % G == 0;
      arr_locked = k >= 2 + lk;
      c_out_flat = pat(k);
      ld_valid = 1'($urandom_range(0, 1));
      ld_data = {$urandom, $urandom};
      chk("a_in", a_in_flat, dat ? skew(1'b0, s / G) : 64'd0);
      chk("b_in", b_in_flat, dat ? skew(1'b1, s / G) : 64'd0);
      chk("arr_en", arr_en, k >= 2);
      chk("arr_rst", arr_rst, k < 2);
      chk("busy", busy, 1);
      chk("res_valid_early", res_valid, 0);
      chk("ld_ready_busy", ld_ready, 0);
      if (abort >= 0 && k == fs + abort * G) begin
        ld_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_arr_rst", arr_rst, 1);
        chk("abort_ld_ready", ld_ready, 0);
        tick;
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ld_ready_after", ld_ready, 1);
        chk("abort_a_in", a_in_flat, 0);
        chk("abort_b_in", b_in_flat, 0);
        chk("abort_arr_en", arr_en, 0);
        chk("abort_res_valid", res_valid, 0);
        return;
      end
      tick;
    end
    exp_c = pat(lat - 1);
    for (int d = 0; d <= rd; d++) begin
      c_out_flat = pat(lat + d);
      res_ready = d == rd;
      ld_valid = d == rd ? 1'b0 : 1'($urandom_range(0, 1));
      chk("done_res_valid", res_valid, 1);
      chk("done_arr_en", arr_en, 0);
      chk("done_busy", busy, 1);
      chk("done_ld_ready", ld_ready, 0);
      chk("done_a_in", a_in_flat, 0);
      chk_c("done_c_res", exp_c);
      tick;
    end
    res_ready = 1'b0;
    chk("post_res_valid", res_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_ld_ready", ld_ready, 1);
    chk("post_arr_en", arr_en, 0);
    chk_c("post_c_res", exp_c);
  endtask
  initial begin
    rst = 1'b1;
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_arr_en", arr_en, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_a_in", a_in_flat, 0);
    chk("rst_b_in", b_in_flat, 0);
    chk_c("rst_c_res", '0);
    chk("rst_arr_rst", arr_rst, 1);
    chk("rst_ld_ready", ld_ready, 0);
    rst = 1'b0;
    #1;
    chk("rel_ld_ready", ld_ready, 1);
    chk("rel_arr_rst", arr_rst, 0);
    fill(1'b1);
    load(16, 1'b0);
    run_op(0, 0, -1);
    fill(1'b0);
    load(16, 1'b1);
    run_op(10, 5, -1);
    fill(1'b0);
    load(16, 1'b1);
    run_op($urandom_range(0, 3), 0, 6);
    fill(1'b0);
    load(5, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("partial_busy", busy, 0);
    fill(1'b0);
    load(16, 1'b0);
    run_op($urandom_range(0, 3), $urandom_range(0, 3), -1);
    fill(1'b0);
    load(15, 1'b1);
    ld_valid = 1'b1;
    ld_data = row(15);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    ld_valid = 1'b0;
    #1;
    chk("beat16_rst_busy", busy, 0);
    chk("beat16_rst_ld_ready", ld_ready, 1);
    fill(1'b0);
    load(16, 1'b1);
    run_op($urandom_range(0, 3), $urandom_range(0, 3), -1);
    repeat (3) begin
      fill(1'b0);
      load(16, 1'b1);
      run_op($urandom_range(0, 4), $urandom_range(0, 3), -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

Sequencer for `systolic_array_8x8`. It buffers one 8x8 A operand and one 8x8 B operand received over a valid/ready load port, then clears and enables the array. It drives the diagonal-skewed operand wavefront, waits for drain, and captures the 8x8 C result behind a valid/ready result port. It sits between the LSTM accelerator's operand fetch logic and the array instance.

## Interface
- `data_width`, default 8: operand element width.
- `acc_width`, default 32: accumulator and result element width.
- `drain_cycles`, default 19: zero-input cycles after the last feed step, before C capture. Legal range 1..255.
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `ld_valid`, input, 1: load beat valid.
- `ld_ready`, output, 1: load beat accepted when `ld_valid && ld_ready`.
- `ld_data`, input, 8*data_width: one matrix row; lane c at `[c*data_width +: data_width]` is column c.
- `busy`, output, 1: high in every state except IDLE.
- `arr_rst`, output, 1: array synchronous clear.
- `arr_en`, output, 1: array enable.
- `arr_locked`, input, 1: array `locked` status.
- `a_in_flat`, output, 8*data_width: A skew vector to the array.
- `b_in_flat`, output, 8*data_width: B skew vector to the array.
- `c_out_flat`, input, 64*acc_width: array result; element (r,c) at index r*8+c.
- `res_valid`, output, 1: captured result available.
- `res_ready`, input, 1: result consumed when `res_valid && res_ready`.
- `c_res_flat`, output, 64*acc_width: captured result, same packing as `c_out_flat`.

## Operation
- States: IDLE, CLR, LOCK, FEED, DRAIN, DONE.
- **IDLE**
  - `ld_ready` = 1.
  - Beats 0-7 write A rows 0-7; beats 8-15 write B rows 0-7. A 4-bit beat counter tracks the count.
  - On the 16th accepted beat: go to CLR and clear the beat counter.
- **CLR**
  - `arr_rst` = 1, `arr_en` = 0, for exactly 2 cycles.
  - Then go to LOCK.
- **LOCK**
  - `arr_en` = 1; wait for `arr_locked` = 1.
  - The cycle `arr_locked` is sampled high: go to FEED with step t = 0.
- **FEED**
  - Steps t = 0..14.
  - In the data cycle of step t, lane i (0..7) carries:
    - `a_in_flat` lane i = A[i][t-i]
    - `b_in_flat` lane i = B[t-i][i]
  - A lane is 0 when t-i < 0 or t-i > 7.
  - After step 14: go to DRAIN.
- **DRAIN**
  - `arr_en` = 1; both skew vectors = 0; lasts `drain_cycles` cycles.
  - On the last DRAIN cycle: register `c_out_flat` into `c_res_flat`, then go to DONE.
- **DONE**
  - `res_valid` = 1; `arr_en` = 0, so the array holds its state.
  - On handshake (`res_valid && res_ready`): go to IDLE. `res_valid` drops the next cycle.
  - `c_res_flat` holds its value until the next capture.
- Operand buffers are written only in IDLE. `ld_valid` outside IDLE is ignored.
- No arithmetic is performed here. Values pass through width-preserving; no truncation or extension.

## Timing
- **Reset** (synchronous, takes effect at the next rising edge):
  - state = IDLE, beat counter = 0, step counter = 0, drain counter = 0.
  - `a_in_flat` = `b_in_flat` = 0, `arr_en` = 0, `res_valid` = 0, `c_res_flat` = 0, `busy` = 0.
- `arr_rst` = `rst` OR (state == CLR). The array is therefore cleared whenever the controller is reset.
- `ld_ready` = (state == IDLE) AND NOT `rst`.
- `a_in_flat`, `b_in_flat`, `arr_en` and `res_valid` are registered.
- **Reset mid-operation** (any state): abandons the operation. Partial load beats are discarded; a pending result is dropped (`res_valid` = 0).
- **Latency**, counted from the 16th beat edge to `res_valid` high, with L = number of LOCK cycles (minimum 1):
  - `SYSTOLIC_GAP_EN` defined: 2 + L + 30 + `drain_cycles`.
  - `SYSTOLIC_GAP_EN` undefined: 2 + L + 15 + `drain_cycles`.
- `arr_locked` already high on LOCK entry: L = 1.
- **DONE with `res_ready` held high**: `res_valid` is high for exactly 1 cycle.
- **16th beat and `rst` in the same cycle**: `rst` wins; state stays IDLE.

## Configuration
- Macro `SYSTOLIC_GAP_EN`.
- Defined: each FEED step is 2 cycles, a data cycle followed by an all-zero bubble cycle. FEED lasts 30 cycles.
- Undefined: steps are back-to-back, one cycle each. FEED lasts 15 cycles; no bubbles.

## Test plan
- **Load and skew, gap on.** Load A[i][j] = 8i+j+1 and B[r][c] = 64-(8r+c).
  - Step 0: a lane0 = 1, b lane0 = 64, all other lanes 0.
  - Step 7: a lane7 = 57, b lane7 = 57.
  - Step 14: a lane7 = 64, b lane7 = 1.
  - Each data cycle is followed by one all-zero cycle.
- **End-to-end with real array**, same operands: `c_res_flat`(0,0) = 960; `res_valid` rises exactly 2+1+30+19 = 52 cycles after the 16th beat.
- **Lock stall**: hold `arr_locked` low for 10 cycles after CLR → FEED starts on the first cycle it is sampled high. Skew vectors stay 0 and `arr_en` = 1 throughout the stall.
- **Result backpressure**: `res_ready` low for 5 cycles → `res_valid` and `c_res_flat` stable; `ld_ready` = 0 until the handshake; IDLE the cycle after.
- **Reset mid-FEED at step 6** → next cycle: `busy` = 0, `ld_ready` = 1, skew vectors = 0, `arr_rst` = 1 during reset. A subsequent full 16-beat load completes normally.
- **Gap off** (macro undefined): no zero bubbles between steps; `res_valid` 2+1+15+19 = 37 cycles after the 16th beat.
